// File: rtl/run_ctrl_if.sv
// Handshake bundle between the run controller and the program-counter / decode side.
// Slave is the controller; master drives decode, stall and LUT-programming inputs.
interface run_ctrl_if #(
  parameter int unsigned L  = 10,
  parameter int unsigned CW = 16,
  parameter int unsigned IW = 5
);
  logic          Start;
  logic          Halt;
  logic          Stall;
  logic          BrReq;
  logic          BrCond;
  logic [IW-1:0] BrIdx;
  logic          LutWe;
  logic [IW-1:0] LutWAddr;
  logic [L-1:0]  LutWData;
  logic          PcClear;
  logic          En;
  logic          BranchEn;
  logic [L-1:0]  Target;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] CycleCount;

  modport slave (
    input  Start, Halt, Stall, BrReq, BrCond, BrIdx, LutWe, LutWAddr, LutWData,
    output PcClear, En, BranchEn, Target, Busy, Done, CycleCount
  );

  modport master (
    output Start, Halt, Stall, BrReq, BrCond, BrIdx, LutWe, LutWAddr, LutWData,
    input  PcClear, En, BranchEn, Target, Busy, Done, CycleCount
  );
endinterface

// File: rtl/run_ctrl.sv
// Run-control and branch-target stage feeding the program counter: sequences
// IDLE/START/RUN/DONE, gates the PC on stall/halt and serves branch targets from a LUT.
module run_ctrl #(
  parameter int unsigned L         = 10,
  parameter int unsigned LUT_DEPTH = 32,
  parameter int unsigned CW        = 16
) (
  input logic        Clk,
  input logic        Reset,
  run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
  logic [L-1:0]  r_lut [LUT_DEPTH];

  logic w_pc_clear;
  logic w_en;
  logic w_branch_en;
  logic w_busy;
  logic w_done;
  logic w_go;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        r_lut[i] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (bus.LutWe) begin
        r_lut[bus.LutWAddr] <= bus.LutWData;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_pc_clear  = 1'b0;
    w_en        = 1'b0;
    w_branch_en = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_go        = ~bus.Stall & ~bus.Halt;
    unique case (r_state)
      StIdle: begin
        if (bus.Start) begin
          w_state_d = StStart;
          w_cnt_d   = '0;
        end
      end
      StStart: begin
        w_pc_clear = 1'b1;
        w_busy     = 1'b1;
        w_state_d  = StRun;
      end
      StRun: begin
        w_busy      = 1'b1;
        w_en        = w_go;
        w_branch_en = w_go & bus.BrReq & bus.BrCond;
        // Counts stalled cycles and the halt cycle too; saturates instead of wrapping.
        if (r_cnt != {CW{1'b1}}) begin
          w_cnt_d = r_cnt + 1'b1;
        end
        if (bus.Halt && !bus.Stall) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_done = 1'b1;
        if (bus.Start) begin
          w_state_d = StStart;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.PcClear    = w_pc_clear;
  assign bus.En         = w_en;
  assign bus.BranchEn   = w_branch_en;
  assign bus.Busy       = w_busy;
  assign bus.Done       = w_done;
  assign bus.CycleCount = r_cnt;
  assign bus.Target     = r_lut[bus.BrIdx];

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized self-checking bench for run_ctrl against a cycle-level behavioural model.
module tb_run_ctrl;
  localparam int unsigned L  = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned VW = L + CW + 5;

  logic Clk;
  logic Reset;
  int   errs;
  int   checks;

  run_ctrl_if #(.L(L), .CW(CW), .IW(5)) bus ();

  run_ctrl #(.L(L), .LUT_DEPTH(32), .CW(CW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: phase 0 idle, 1 start, 2 run, 3 done.
  int          m_phase;
  int          m_cnt;
  logic [L-1:0] m_lut [32];

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  task automatic model_edge();
    if (bus.LutWe) m_lut[bus.LutWAddr] = bus.LutWData;
    case (m_phase)
      0, 3: if (bus.Start) begin m_phase = 1; m_cnt = 0; end
      1: m_phase = 2;
      2: begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (bus.Halt && !bus.Stall) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic run, go;
    run = (m_phase == 2);
    go  = run && !bus.Stall && !bus.Halt;
    return {m_phase == 1, go, go && bus.BrReq && bus.BrCond, m_phase == 1 || run,
            m_phase == 3, m_lut[bus.BrIdx], 16'(m_cnt)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {bus.PcClear, bus.En, bus.BranchEn, bus.Busy, bus.Done, bus.Target,
            bus.CycleCount};
  endfunction

  task automatic clk_step();
    @(posedge Clk);
    if (!Reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.BrReq = 0; bus.BrCond = 0;
    bus.BrIdx = '0; bus.LutWe = 0; bus.LutWAddr = '0; bus.LutWData = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 0;
    model_reset();
    clk_step();
    clk_step();
    #2;
    checks++;
    if ({bus.En, bus.PcClear, bus.Busy, bus.Done, bus.CycleCount} !== '0) begin
      errs++;
      $display("FAIL reset_hold: got %h exp 0", {bus.En, bus.PcClear, bus.Busy, bus.Done});
    end
    Reset = 1;
    for (int i = 0; i < 5; i++) begin
      bus.BrIdx = 5'($urandom);
      #2;
      checks++;
      if (obs_vec() !== exp_vec() || obs_vec() !== '0) begin
        errs++;
        $display("FAIL reset_idle: got %h exp %h", obs_vec(), exp_vec());
      end
      clk_step();
    end
  endtask

  task automatic test_basic_run();
    int en_n, pc_n;
    en_n = 0; pc_n = 0;
    bus.Start = 1;
    clk_step();
    bus.Start = 0;
    #2;
    checks++;
    if (bus.PcClear !== 1'b1 || bus.En !== 1'b0 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL start_cycle: got %h exp %h", obs_vec(), exp_vec());
    end
    pc_n += int'(bus.PcClear);
    clk_step();
    for (int k = 1; k <= 6; k++) begin
      bus.Halt = (k == 6);
      #2;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL run_cycle%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
      en_n += int'(bus.En);
      pc_n += int'(bus.PcClear);
      clk_step();
    end
    bus.Halt = 0;
    #2;
    checks++;
    if (bus.Done !== 1'b1 || bus.CycleCount !== 16'd6 || en_n != 5 || pc_n != 1) begin
      errs++;
      $display("FAIL basic_done: got done=%b cnt=%0d en=%0d pc=%0d exp 1 6 5 1",
               bus.Done, bus.CycleCount, en_n, pc_n);
    end
    clk_step();
  endtask

  task automatic test_branch();
    bus.LutWe = 1; bus.LutWAddr = 5'd3; bus.LutWData = 10'h155;
    clk_step();
    bus.LutWe = 0;
    bus.Start = 1;
    clk_step();
    bus.Start = 0;
    clk_step();
    bus.BrReq = 1; bus.BrIdx = 5'd3; bus.BrCond = 1;
    #2;
    checks++;
    if (bus.BranchEn !== 1'b1 || bus.Target !== 10'h155 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL branch_taken: got be=%b tgt=%h exp 1 155", bus.BranchEn, bus.Target);
    end
    clk_step();
    bus.BrCond = 0;
    #2;
    checks++;
    if (bus.BranchEn !== 1'b0 || bus.En !== 1'b1 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL branch_not_taken: got be=%b en=%b exp 0 1", bus.BranchEn, bus.En);
    end
    clk_step();
  endtask

  task automatic test_stall_halt();
    int c0;
    c0 = m_cnt;
    bus.Stall = 1; bus.Halt = 1; bus.BrReq = 1; bus.BrCond = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++;
      if (bus.En !== 1'b0 || bus.BranchEn !== 1'b0 || bus.Busy !== 1'b1 ||
          bus.Done !== 1'b0 || obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL stall_hold%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
      clk_step();
    end
    bus.Stall = 0;
    clk_step();
    bus.Halt = 0; bus.BrReq = 0; bus.BrCond = 0;
    #2;
    checks++;
    if (bus.Done !== 1'b1 || int'(bus.CycleCount) != c0 + 4) begin
      errs++;
      $display("FAIL stall_done: got done=%b cnt=%0d exp 1 %0d", bus.Done, bus.CycleCount,
               c0 + 4);
    end
    clk_step();
  endtask

  task automatic test_collision();
    bus.LutWe = 1; bus.LutWAddr = 5'd7; bus.LutWData = 10'h2A; bus.BrIdx = 5'd7;
    #2;
    checks++;
    if (bus.Target !== 10'h000) begin
      errs++;
      $display("FAIL collide_old: got %h exp 000", bus.Target);
    end
    clk_step();
    bus.LutWe = 0;
    #2;
    checks++;
    if (bus.Target !== 10'h02A || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL collide_new: got %h exp 02a", bus.Target);
    end
  endtask

  task automatic test_restart_reset();
    bus.Start = 1;
    clk_step();
    bus.Start = 0;
    #2;
    checks++;
    if (bus.PcClear !== 1'b1 || bus.CycleCount !== 16'd0) begin
      errs++;
      $display("FAIL restart: got pc=%b cnt=%0d exp 1 0", bus.PcClear, bus.CycleCount);
    end
    clk_step();
    clk_step();
    bus.BrIdx = 5'd3; bus.BrReq = 1; bus.BrCond = 1;
    #2;
    Reset = 0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errs++;
      $display("FAIL async_reset: got %h exp 0", obs_vec());
    end
    #2;
    Reset = 1;
    bus.BrReq = 0; bus.BrCond = 0;
    clk_step();
    #2;
    checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL post_reset_idle: got %h exp %h", obs_vec(), exp_vec());
    end
    clk_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.Start    = ($urandom_range(0, 4) == 0);
      bus.Stall    = ($urandom_range(0, 3) == 0);
      bus.Halt     = ($urandom_range(0, 9) == 0);
      bus.BrReq    = 1'($urandom);
      bus.BrCond   = 1'($urandom);
      bus.BrIdx    = 5'($urandom);
      bus.LutWe    = ($urandom_range(0, 3) == 0);
      bus.LutWAddr = ($urandom_range(0, 1) == 0) ? bus.BrIdx : 5'($urandom);
      bus.LutWData = 10'($urandom);
      #2;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL random%0d: got %h exp %h", i, obs_vec(), exp_vec());
      end
      clk_step();
    end
    clear_inputs();
  endtask

  task automatic test_saturate();
    Reset = 0;
    #2;
    Reset = 1;
    model_reset();
    bus.Start = 1;
    clk_step();
    bus.Start = 0;
    for (int i = 0; i < 65545; i++) begin
      bus.Stall = ($urandom_range(0, 7) == 0);
      clk_step();
    end
    bus.Stall = 0;
    #2;
    checks++;
    if (bus.CycleCount !== 16'hFFFF || bus.Busy !== 1'b1 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL saturate: got cnt=%h busy=%b exp ffff 1", bus.CycleCount, bus.Busy);
    end
    bus.Halt = 1;
    clk_step();
    bus.Halt = 0;
    #2;
    checks++;
    if (bus.CycleCount !== 16'hFFFF || bus.Done !== 1'b1) begin
      errs++;
      $display("FAIL saturate_done: got cnt=%h done=%b exp ffff 1", bus.CycleCount, bus.Done);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    Reset = 0;
    clear_inputs();
    test_reset();
    test_basic_run();
    test_branch();
    test_stall_halt();
    test_collision();
    test_restart_reset();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
